// File: rtl/chacha_pkg.sv
// Shared constants, state-image layout and FSM encoding for the ChaCha20 job controller.
package chacha_pkg;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    localparam int STATE_BYTES = 64;
    localparam int NUM_ROUNDS  = 20;
    localparam int KEY_BYTES   = 32;
    localparam int NONCE_BYTES = 12;

    // Byte offsets inside the 64-byte state image
    localparam logic [5:0] KEY_OFS   = 6'd16;
    localparam logic [5:0] CTR_OFS   = 6'd48;
    localparam logic [5:0] NONCE_OFS = 6'd52;

    // Host config address map (key 0-31, counter 32-35, nonce 36-47)
    localparam logic [5:0] CFG_CTR_BASE   = 6'd32;
    localparam logic [5:0] CFG_NONCE_BASE = 6'd36;
    localparam logic [5:0] CFG_END        = 6'd48;

    localparam logic [5:0] LAST_IDX = 6'(STATE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    function automatic logic [7:0] sigma_byte(input logic [3:0] idx);
        logic [127:0] s;
        s = {SIGMA3, SIGMA2, SIGMA1, SIGMA0};
        return s[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/chacha_cfg_regs.sv
// Shadow key/counter/nonce registers: host byte writes, byte reads by state-image address.
module chacha_cfg_regs
    import chacha_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [5:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    input  logic [5:0]  rd_addr_i,
    output logic [7:0]  rd_data_o,
    input  logic        ctr_inc_i,
    output logic [31:0] ctr_o
);

    logic [7:0]  key_q   [KEY_BYTES];
    logic [7:0]  nonce_q [NONCE_BYTES];
    logic [31:0] ctr_q;

    logic [3:0] wr_nonce_idx;
    logic [4:0] rd_key_idx;
    logic [3:0] rd_nonce_idx;

    assign wr_nonce_idx = 4'(wr_addr_i - CFG_NONCE_BASE);
    assign rd_key_idx   = 5'(rd_addr_i - KEY_OFS);
    assign rd_nonce_idx = 4'(rd_addr_i - NONCE_OFS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_BYTES; i++) key_q[i] <= 8'h00;
            for (int i = 0; i < NONCE_BYTES; i++) nonce_q[i] <= 8'h00;
            ctr_q <= 32'h0;
        end else if (ctr_inc_i) begin
            ctr_q <= ctr_q + 32'd1;
        end else if (wr_en_i) begin
            if (wr_addr_i < CFG_CTR_BASE) begin
                key_q[wr_addr_i[4:0]] <= wr_data_i;
            end else if (wr_addr_i < CFG_NONCE_BASE) begin
                ctr_q[{wr_addr_i[1:0], 3'b000} +: 8] <= wr_data_i;
            end else if (wr_addr_i < CFG_END) begin
                nonce_q[wr_nonce_idx] <= wr_data_i;
            end
        end
    end

    // CTR_OFS is word aligned, so the low address bits select the counter byte directly
    always_comb begin
        rd_data_o = 8'h00;
        if (rd_addr_i < KEY_OFS) begin
            rd_data_o = sigma_byte(rd_addr_i[3:0]);
        end else if (rd_addr_i < CTR_OFS) begin
            rd_data_o = key_q[rd_key_idx];
        end else if (rd_addr_i < NONCE_OFS) begin
            rd_data_o = ctr_q[{rd_addr_i[1:0], 3'b000} +: 8];
        end else begin
            rd_data_o = nonce_q[rd_nonce_idx];
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/chacha_ctrl.sv
// ChaCha20 job controller: loads the state image into the block core, then streams keystream bytes.
module chacha_ctrl
    import chacha_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [5:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        start,
    input  logic [7:0]  num_blocks,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ctr_out,
    output logic [7:0]  ks_data,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        ks_last,
    output logic        blk_write,
    output logic [5:0]  blk_addr,
    output logic [7:0]  blk_data_in,
    input  logic [7:0]  blk_data_out,
    input  logic        blk_ready
);

    state_e     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [5:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       cfg_wr;
    logic       ctr_inc;
    logic [7:0] state_byte;

    chacha_cfg_regs u_cfg_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (cfg_wr),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_addr_i (idx_q),
        .rd_data_o (state_byte),
        .ctr_inc_i (ctr_inc),
        .ctr_o     (ctr_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= 8'h00;
            idx_q   <= 6'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Valid/ready: ks_valid holds with stable ks_data until a cycle with ks_ready high accepts the byte.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cfg_wr  = 1'b0;
        ctr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_wr = cfg_we;
                idx_d  = 6'h00;
                if (start) begin
                    err_d = 1'b0;
                    if (num_blocks == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = num_blocks;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == LAST_IDX) state_d = WAIT;
            end
            WAIT: begin
                if (blk_ready) state_d = OUT;
            end
            OUT: begin
                if (ks_ready) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        ctr_inc = 1'b1;
                        rem_d   = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (ctr_out == 32'hFFFF_FFFF) begin
                            // Counter would repeat a keystream block: abort the job
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            rem_d   = 8'h00;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign blk_write   = (state_q == LOAD);
    assign blk_addr    = (state_q == LOAD || state_q == OUT) ? idx_q : 6'h00;
    assign blk_data_in = (state_q == LOAD) ? state_byte : 8'h00;
    assign ks_valid    = (state_q == OUT);
    assign ks_data     = (state_q == OUT) ? blk_data_out : 8'h00;
    assign ks_last     = (state_q == OUT) && (idx_q == LAST_IDX) && (rem_q == 8'd1);

endmodule

// File: tb/tb_chacha_ctrl.sv
// Directed bench for chacha_ctrl with a behavioural ChaCha20 block core on the blk_* ports.
module tb_chacha_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        start;
    logic [7:0]  num_blocks;
    logic        busy, done, err;
    logic [31:0] ctr_out;
    logic [7:0]  ks_data;
    logic        ks_valid, ks_ready, ks_last;
    logic        blk_write;
    logic [5:0]  blk_addr;
    logic [7:0]  blk_data_in, blk_data_out;
    logic        blk_ready = 1'b0;

    chacha_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .num_blocks(num_blocks), .busy(busy), .done(done), .err(err),
        .ctr_out(ctr_out), .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .ks_last(ks_last), .blk_write(blk_write), .blk_addr(blk_addr),
        .blk_data_in(blk_data_in), .blk_data_out(blk_data_out), .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] key_b   [32];
    logic [7:0] nonce_b [12];
    logic [7:0] got_q[$];
    int         last_pos_q[$];
    int         load_lens[$];
    int         stall_err, done_cyc, addr_err = 0;
    bit         busy_seen, wr_seen, timed_out, busy_after_start, busy_at_done;

    // ---------------- reference ChaCha20 ----------------
    function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [511:0] in);
        logic [31:0]  x [16];
        logic [511:0] o;
        for (int i = 0; i < 16; i++) x[i] = in[32*i +: 32];
        for (int r = 0; r < 10; r++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + in[32*i +: 32];
        return o;
    endfunction

    function automatic logic [511:0] build_image(input logic [31:0] ctr);
        logic [511:0] im;
        im[127:0] = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        for (int i = 0; i < 32; i++) im[128 + 8*i +: 8] = key_b[i];
        im[384 +: 32] = ctr;
        for (int i = 0; i < 12; i++) im[416 + 8*i +: 8] = nonce_b[i];
        return im;
    endfunction

    // ---------------- block core model ----------------
    logic [511:0] img = '0, core_ks = '0, last_img = '0;
    int  wcnt = 0, wait_cnt = 0;
    bit  in_load = 0;

    always @(negedge clk) begin
        if (blk_write) begin
            if (blk_addr !== 6'(wcnt)) addr_err++;
            img[int'(blk_addr)*8 +: 8] = blk_data_in;
            wcnt++;
            blk_ready = 1'b0;
            in_load = 1;
        end else if (in_load) begin
            in_load = 0;
            load_lens.push_back(wcnt);
            wcnt = 0;
            last_img = img;
            core_ks = chacha_block(img);
            wait_cnt = 160;
        end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) blk_ready = 1'b1;
        end
    end

    assign blk_data_out = core_ks[int'(blk_addr)*8 +: 8];

    // ---------------- checks and drivers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_ctr(input logic [31:0] ctr);
        for (int i = 0; i < 4; i++) cfg_write(6'(32 + i), ctr[8*i +: 8]);
    endtask

    task automatic load_cfg(input logic [31:0] ctr);
        for (int i = 0; i < 32; i++) cfg_write(6'(i), key_b[i]);
        load_ctr(ctr);
        for (int i = 0; i < 12; i++) cfg_write(6'(36 + i), nonce_b[i]);
    endtask

    function automatic logic [7:0] got(input int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or stop_at bytes accepted)
    task automatic run_job(input logic [7:0] nb, input bit rnd, input int stop_at, input bit poke);
        bit         hold;
        logic [7:0] held;
        got_q.delete(); last_pos_q.delete(); load_lens.delete();
        stall_err = 0; busy_seen = 0; wr_seen = 0; timed_out = 1; done_cyc = -1;
        hold = 0; held = 8'h00; busy_at_done = 1;
        start = 1'b1; num_blocks = nb;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin cfg_addr = 6'd0; cfg_data = 8'hff; num_blocks = 8'd7; end
        busy_after_start = busy;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (busy) busy_seen = 1;
            if (blk_write) wr_seen = 1;
            if (done) begin done_cyc = cyc; busy_at_done = busy; timed_out = 0; break; end
            if (stop_at > 0 && got_q.size() == stop_at) begin timed_out = 0; break; end
            if (hold && ks_valid && ks_data !== held) stall_err++;
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_we = poke && blk_write;
            start  = poke && blk_write;
            if (ks_valid && ks_ready) begin
                got_q.push_back(ks_data);
                if (ks_last) last_pos_q.push_back(got_q.size());
                hold = 0;
            end else begin
                hold = ks_valid;
                held = ks_data;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0; start = 1'b0;
    endtask

    task automatic check_stream(input string tag, input logic [31:0] ctr0, input int nbytes);
        logic [511:0] ks;
        int nerr;
        nerr = 0;
        chk({tag, "_len"}, got_q.size(), nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if (i % 64 == 0) ks = chacha_block(build_image(ctr0 + 32'(i / 64)));
            if (got(i) !== ks[8*(i % 64) +: 8]) nerr++;
        end
        chk({tag, "_bytes_bad"}, nerr, 0);
    endtask

    function automatic int image_diff(input logic [511:0] a, input logic [511:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) if (a[8*i +: 8] !== b[8*i +: 8]) n++;
        return n;
    endfunction

    function automatic int bad_loads();
        int n;
        n = 0;
        foreach (load_lens[i]) if (load_lens[i] != 64) n++;
        return n;
    endfunction

    initial begin
        logic [63:0] first8;
        logic [31:0] last4;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; num_blocks = '0; ks_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {busy, done, err, ks_valid, ks_last, blk_write, blk_addr, blk_data_in, ks_data}, 0);
        chk("rst_ctr", ctr_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // RFC 8439 2.3.2 block
        for (int i = 0; i < 32; i++) key_b[i] = 8'(i);
        nonce_b = '{8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h4a, 8'h00, 8'h00, 8'h00, 8'h00};
        load_cfg(32'd1);
        cfg_write(6'd50, 8'h77);
        chk("cfg_ctr", ctr_out, 32'd1);
        run_job(8'd1, 1'b0, 0, 1'b0);
        chk("rfc_timeout", timed_out, 0);
        chk("rfc_busy_after_start", busy_after_start, 1);
        chk("rfc_busy_at_done", busy_at_done, 0);
        for (int i = 0; i < 8; i++) first8 = {first8[55:0], got(i)};
        for (int i = 60; i < 64; i++) last4 = {last4[23:0], got(i)};
        chk("rfc_first8", first8, 64'h10f1e7e4d13b5915);
        chk("rfc_last4", last4, 32'ha2503c4e);
        check_stream("rfc", 32'd1, 64);
        chk("rfc_image_diff", image_diff(last_img, build_image(32'd1)), 0);
        chk("rfc_loads", load_lens.size(), 1);
        chk("rfc_bad_loads", bad_loads(), 0);
        chk("rfc_addr_err", addr_err, 0);
        chk("rfc_last_cnt", last_pos_q.size(), 1);
        chk("rfc_last_pos", last_pos_q.size() > 0 ? last_pos_q[0] : 0, 64);
        chk("rfc_err", err, 0);
        chk("rfc_ctr", ctr_out, 32'd2);
        @(negedge clk);
        chk("rfc_done_pulse", done, 0);

        // Three blocks with random back-pressure
        load_ctr(32'd1);
        run_job(8'd3, 1'b1, 0, 1'b0);
        chk("multi_timeout", timed_out, 0);
        check_stream("multi", 32'd1, 192);
        chk("multi_stall", stall_err, 0);
        chk("multi_ctr", ctr_out, 32'd4);
        chk("multi_loads", load_lens.size(), 3);
        chk("multi_bad_loads", bad_loads(), 0);
        chk("multi_addr_err", addr_err, 0);
        chk("multi_last_cnt", last_pos_q.size(), 1);
        chk("multi_last_pos", last_pos_q.size() > 0 ? last_pos_q[0] : 0, 192);
        @(negedge clk);
        chk("multi_done_pulse", done, 0);

        // Counter wrap with blocks remaining
        load_ctr(32'hFFFF_FFFE);
        run_job(8'd5, 1'b0, 0, 1'b0);
        chk("wrap_timeout", timed_out, 0);
        check_stream("wrap", 32'hFFFF_FFFE, 128);
        chk("wrap_err", err, 1);
        chk("wrap_ctr", ctr_out, 32'd0);
        chk("wrap_busy", busy, 0);

        // Zero-block job clears err and finishes immediately
        run_job(8'd0, 1'b0, 0, 1'b0);
        chk("zero_done_cyc", done_cyc, 0);
        chk("zero_err", err, 0);
        chk("zero_busy", busy_seen || busy_after_start, 0);
        chk("zero_wr", wr_seen, 0);
        @(negedge clk);
        chk("zero_done_pulse", done, 0);
        chk("zero_wr_after", blk_write, 0);

        // Config writes and start while busy, then reset at byte 20
        load_ctr(32'd5);
        run_job(8'd2, 1'b0, 20, 1'b1);
        chk("busy_timeout", timed_out, 0);
        check_stream("busy", 32'd5, 20);
        chk("busy_ctr", ctr_out, 32'd5);
        chk("busy_state", {busy, ks_valid}, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {busy, done, err, ks_valid, ks_last, blk_write, blk_addr, blk_data_in, ks_data}, 0);
        chk("midrst_ctr", ctr_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) key_b[i] = 8'h00;
        for (int i = 0; i < 12; i++) nonce_b[i] = 8'h00;
        run_job(8'd1, 1'b0, 0, 1'b0);
        chk("post_timeout", timed_out, 0);
        chk("post_image_diff", image_diff(last_img, build_image(32'd0)), 0);
        check_stream("post", 32'd0, 64);
        chk("post_ctr", ctr_out, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_ctrl.md
CHACHA_CTRL -- requirements
Module: chacha_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low; clock clk.
REQ-002 cfg_we  in  1  host config byte write strobe.
REQ-003 cfg_addr  in  6  config byte address: 0-31 key, 32-35 block counter (LE), 36-47 nonce; 48-63 ignored.
REQ-004 cfg_data  in  8  config write byte.
REQ-005 start  in  1  begin job; num_blocks  in  8  blocks to generate, sampled with start.
REQ-006 busy  out  1  job in progress; done  out  1  one-cycle pulse at job end; err  out  1  sticky counter-wrap flag.
REQ-007 ctr_out  out  32  current block counter.
REQ-008 ks_data  out  8  keystream byte; ks_valid  out  1; ks_ready  in  1; ks_last  out  1  final byte of job.
REQ-009 blk_write  out  1; blk_addr  out  6; blk_data_in  out  8; blk_data_out  in  8; blk_ready  in  1 (block core ports).

Function
REQ-010 State image byte n SHALL be byte n%4 (little-endian) of word n/4: words 0-3 "expand 32-byte k" (61707865, 3320646e, 79622d32, 6b206574), 4-11 key, 12 counter, 13-15 nonce.
REQ-011 FSM states SHALL be IDLE, LOAD, WAIT, OUT.
REQ-012 IDLE: cfg_we writes shadow byte at cfg_addr; cfg_we outside IDLE SHALL be ignored.
REQ-013 IDLE, start=1, num_blocks>0: latch num_blocks, clear err, busy=1 next cycle, go LOAD. start in any other state ignored.
REQ-014 start with num_blocks=0: done pulses next cycle, no block port activity, err cleared.
REQ-015 LOAD: 64 cycles, blk_write=1, blk_addr=0..63 ascending one per cycle, blk_data_in=state byte blk_addr; then WAIT.
REQ-016 WAIT: blk_write=0, blk_addr=0; go OUT on first cycle blk_ready=1 (core asserts it 160 cycles after write deasserts); no timeout.
REQ-017 OUT: blk_write=0, blk_addr=byte index i (0..63), ks_data=blk_data_out combinationally, ks_valid=1; i advances only on ks_valid&&ks_ready; ks_valid held with stable data until accepted.
REQ-018 ks_last=1 only with byte 63 of final block of job.
REQ-019 On acceptance of byte 63: counter increments mod 2^32, remaining count decrements; if zero go IDLE with done pulse and busy=0 same cycle as IDLE entry; else LOAD.
REQ-020 Counter wrap: if counter was FFFFFFFF at block completion and blocks remain, counter becomes 0, err=1, job ends (IDLE, done pulse); final-block completion with wrap sets counter 0 without err.
REQ-021 ctr_out SHALL reflect shadow counter at all times, including host writes.
REQ-022 Outside OUT ks_valid=0, ks_last=0, ks_data=0; outside LOAD blk_write=0.

Reset
REQ-023 rst_n=0 at clk edge SHALL force IDLE from any state, including mid-LOAD/WAIT/OUT.
REQ-024 Reset values: key, nonce, counter, remaining count, byte index = 0; busy, done, err, ks_valid, ks_last, blk_write = 0; blk_addr, blk_data_in, ks_data = 0.

Structure
REQ-025 Shared package chacha_pkg SHALL hold: sigma constant words, state byte offsets (key 16, counter 48, nonce 52), STATE_BYTES=64, NUM_ROUNDS=20, FSM state enum.
REQ-026 Shadow key/counter/nonce register file SHALL be sub-module chacha_cfg_regs (byte write, byte read by state address, counter increment port).

Verification
REQ-027 RFC 8439 2.3.2: key 00..1f, nonce 00000009 0000004a 00000000, counter 1, num_blocks=1, ks_ready=1 -> bytes 10 f1 e7 e4 d1 3b 59 15 ..., 64 bytes, ks_last on byte 64, done once, ctr_out=2.
REQ-028 Same config, num_blocks=3, ks_ready toggling 50% random -> 192 bytes, no drop/dup, ks_data stable while stalled, ctr_out=4, each LOAD exactly 64 blk_write cycles.
REQ-029 Counter FFFFFFFE, num_blocks=5 -> 2 blocks output, then done, err=1, ctr_out=0; next start clears err.
REQ-030 num_blocks=0 start -> done pulse next cycle, blk_write never asserted, busy stays 0.
REQ-031 rst_n low mid-OUT (byte 20) -> next cycle IDLE, all outputs 0, shadow regs 0; cfg_we and start during busy have no effect.
